// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a show-ahead RX FIFO.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   uart_rx       serial input (idle high, asynchronous to clk)
//   rd_en         pop the FIFO head byte (ignored while empty)
//   clr_err       clear sticky overrun / frame_err
//   rd_data       FIFO head byte, 0 while empty
//   rx_valid      FIFO not empty; irq mirrors it
//   rx_count      bytes currently held in the FIFO
//   overrun       sticky: a good byte was dropped on a full FIFO
//   frame_err     sticky: a stop bit was sampled low
//   sim_rx_valid  one-cycle pulse per pushed byte, with sim_rx_data
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic [7:0]         rd_data,
  output logic               rx_valid,
  output logic [FIFO_AW:0]   rx_count,
  output logic               overrun,
  output logic               frame_err,
  output logic               irq,
  output logic               sim_rx_valid,
  output logic [7:0]         sim_rx_data
);

  localparam int CW    = $clog2(CLKS_PER_BIT) + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] FULL_CNT    = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic                 sim_vld_q, sim_vld_d;
  logic [7:0]           sim_data_q, sim_data_d;

  logic rxs, tick, full, pop, push;
  logic load_half, load_full, shift_en, bit_clr, stop_good, frame_set, overrun_set;

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);
  assign full = (count_q == FULL_CNT);
  assign pop  = rd_en && (count_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxs) state_d = START;
      START:     if (tick) state_d = rxs ? IDLE : DATA;   // high at mid-start = glitch
      DATA:      if (tick && bit_idx_q == 3'd7) state_d = STOP;
      STOP:      if (tick) state_d = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_d = IDLE;                 // a held-low line yields one error only
      default:   state_d = IDLE;
    endcase
  end

  // Control strobes decoded from state
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    stop_good = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE:  load_half = !rxs;
      START: begin
        load_full = tick && !rxs;
        bit_clr   = tick && !rxs;
      end
      DATA: begin
        shift_en  = tick;
        load_full = tick;
      end
      STOP: begin
        stop_good = tick && rxs;
        frame_set = tick && !rxs;
      end
      default: ;
    endcase
  end

  // A full FIFO still accepts the byte if the head leaves in the same cycle;
  // the freed slot is exactly the one wr_ptr points at.
  assign push        = stop_good && (!full || pop);
  assign overrun_set = stop_good && full && !pop;

  // Datapath next-state
  always_comb begin
    sync_d = {sync_q[0], uart_rx};

    cnt_d = cnt_q;
    if (load_half)       cnt_d = HALF_RELOAD;
    else if (load_full)  cnt_d = FULL_RELOAD;
    else if (!tick)      cnt_d = cnt_q - CW'(1);

    bit_idx_d = bit_idx_q;
    if (bit_clr)       bit_idx_d = 3'd0;
    else if (shift_en) bit_idx_d = bit_idx_q + 3'd1;

    shift_d = shift_en ? {rxs, shift_q[7:1]} : shift_q;   // LSB first

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = shift_q;
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: ;
    endcase

    // A new error event outranks a clear in the same cycle
    overrun_d   = overrun_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    frame_err_d = frame_set   ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);

    sim_vld_d  = push;
    sim_data_d = push ? shift_q : sim_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      sim_vld_q   <= 1'b0;
      sim_data_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      sim_vld_q   <= sim_vld_d;
      sim_data_q  <= sim_data_d;
    end
  end

  assign rx_valid     = (count_q != '0);
  assign rd_data      = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_count     = count_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;
  assign irq          = rx_valid;
  assign sim_rx_valid = sim_vld_q;
  assign sim_rx_data  = sim_data_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel 8N1 UART receiver with an RX FIFO. It is the receive side of the SoC UART: it deserializes the uart_rx pin and presents bytes to the CPU-facing register interface, where the host or bench types input for the shell. It includes error flags, an interrupt level, and a simulation byte strobe that mirrors the existing TX sim strobe.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
uart_rx  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop request for the head byte
clr_err  in  1  clears the sticky overrun and frame_err flags
rd_data  out  8  FIFO head byte (show-ahead), valid when rx_valid=1
rx_valid  out  1  FIFO not empty
rx_count  out  FIFO_AW+1  number of bytes in the FIFO
overrun  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit sampled low
irq  out  1  equals rx_valid (level interrupt)
sim_rx_valid  out  1  one-cycle pulse when a good byte is pushed
sim_rx_data  out  8  byte pushed, valid with sim_rx_valid

Behaviour:
- Synchronous, active-high reset. Every output reads 0 at reset (rd_data=0, rx_count=0, flags=0). The 2-flop synchronizer resets to 1. The FSM resets to IDLE, pointers and bit counter to 0.
- Reset asserted mid-frame abandons the frame. The FIFO is emptied. Reception resumes only on the next falling edge seen after reset.
- uart_rx passes through a 2-flop synchronizer; the FSM sees only its output rxs (2-cycle latency).
- The baud counter is a down-counter of width clog2(CLKS_PER_BIT)+1. A "tick" is the count reaching 0; the counter reloads on each tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rxs=0, load the counter with CLKS_PER_BIT/2 (integer division) minus 1 and go to START.
- START: on tick, if rxs=0 go to DATA, load CLKS_PER_BIT-1, bit index 0. If rxs=1 it is a glitch: go to IDLE, no flags.
- DATA: on tick, shift rxs in LSB first. After bit index 7, go to STOP; the counter reloads CLKS_PER_BIT-1 on every tick.
- STOP, on tick with rxs=1:
  - if the FIFO is not full, or rd_en pops in the same cycle, push the byte, pulse sim_rx_valid, go to IDLE;
  - otherwise set overrun, drop the byte, go to IDLE.
- STOP, on tick with rxs=0: set frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. A line break never produces repeated frames.
- Push timing: the push is registered at the STOP tick edge. rx_valid and the rx_count increment are visible the next cycle.
- Pop: rd_en with rx_valid=1 advances the read pointer at the edge. rd_data shows the new head next cycle. rd_en with rx_valid=0 is ignored and has no effect on the flags.
- Simultaneous push and pop: count unchanged, both pointers advance, no overrun even when full.
- Pointers are FIFO_AW bits and wrap modulo depth. Full means rx_count = 2**FIFO_AW.
- Sticky flags: clr_err clears them. If clr_err coincides with a new error event, the event wins and the flag stays 1.
- Nominal end-to-end latency: the falling start edge at cycle 0 reaches the push at about 2 + 9.5×CLKS_PER_BIT cycles.

Test Plan:
- Idle line after reset, 1000 cycles, uart_rx=1 → rx_valid=0, rx_count=0, no sim_rx_valid pulse, flags 0.
- CLKS_PER_BIT=16, send 0x41 then 0x0A back-to-back → sim_rx_valid pulses twice with 0x41 then 0x0A. rx_count=2, rd_data=0x41; after one rd_en, rd_data=0x0A, rx_count=1.
- Start glitch: uart_rx low for 5 cycles (< half bit of 8) → returns to IDLE, nothing pushed, no flags. A following valid 0x55 is received correctly.
- Frame error: send 0xA5 with stop bit 0, then hold low for 40 bit times → frame_err=1, rx_count=0, exactly one frame consumed. After the line rises, 0x33 is received. clr_err clears frame_err.
- Overflow: send 17 bytes 0x00..0x10 without reads → rx_count=16, overrun=1, FIFO holds 0x00..0x0F. The same test with rd_en asserted at the 17th STOP tick → 0x10 is accepted, overrun stays 0.
- Reset mid-frame after 4 data bits (rst high for 1 cycle) → all outputs 0. The next full frame 0x7E is received intact.
